present_decrypt: RTL and testbench

//  Iterative PRESENT-80 block decryptor; inverse of the encrypt core, sharing its ports and load/done handshake.

---
 rtl/present_decrypt.sv | 236 +++++++++++++++++++++++
 tb/tb_present_decrypt.sv | 209 ++++++++++++++++++++
 2 files changed

// File: rtl/present_decrypt.sv
// rtl/present_decrypt.sv - iterative PRESENT-80 block decryptor with load/done handshake
//
// Purpose: decrypts one 64-bit block under an 80-bit user key. The key register
// is first walked forward to the last round key K32 (one update per clock), and
// the ciphertext is whitened with K32. Then one inverse round per clock is applied:
// inverse pLayer, inverse sLayer, XOR with the key obtained by undoing one
// schedule step.
//
// Ports:
//   clk          clock, all logic on posedge
//   rst          synchronous active-high reset
//   chip_enable  1 = run, 0 = freeze state (done/odat forced low)
//   load         start request, sampled in IDLE only
//   idat[63:0]   ciphertext, sampled with load
//   key[79:0]    user key K1, sampled with load
//   odat[63:0]   plaintext, valid while done=1, held until next load
//   done         one-cycle pulse marking odat valid
//   busy         high from the cycle after an accepted load through the done cycle

module present_decrypt #(
  parameter int unsigned ROUNDS = 31
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        chip_enable,
  input  logic        load,
  input  logic [63:0] idat,
  input  logic [79:0] key,
  output logic [63:0] odat,
  output logic        done,
  output logic        busy
);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_KEYEXP  = 2'd1,
    S_DECRYPT = 2'd2
  } state_e;

  localparam logic [4:0] LAST_ROUND = 5'(ROUNDS);

  state_e      state_q, state_d;
  logic [4:0]  round_q, round_d;
  logic [79:0] kreg_q,  kreg_d;
  logic [63:0] dreg_q,  dreg_d;
  logic [63:0] odat_q,  odat_d;
  logic        done_q,  done_d;

  // Forward schedule step f(kreg, round): rotl61, S on top nibble, round into [19:15].
  logic [79:0] krot_f;
  logic [79:0] key_fwd;
  logic [3:0]  kf_hi;

  assign krot_f = {kreg_q[18:0], kreg_q[79:19]};

  sbox u_key_sbox (
    .x_i (krot_f[79:76]),
    .y_o (kf_hi)
  );

  assign key_fwd = {kf_hi, krot_f[75:20], krot_f[19:15] ^ round_q, krot_f[14:0]};

  // Inverse schedule step g(kreg, round): undo the counter XOR and S, then rotr61.
  logic [79:0] kg_pre;
  logic [79:0] key_bwd;
  logic [3:0]  kg_hi;

  inv_sbox u_key_inv_sbox (
    .x_i (kreg_q[79:76]),
    .y_o (kg_hi)
  );

  assign kg_pre  = {kg_hi, kreg_q[75:20], kreg_q[19:15] ^ round_q, kreg_q[14:0]};
  assign key_bwd = {kg_pre[60:0], kg_pre[79:61]};

  // Inverse round datapath: P^-1, then S^-1 on each nibble, then add the recovered round key.
  logic [63:0] data_p;
  logic [63:0] data_s;
  logic [63:0] data_next;

  inv_pbox u_inv_pbox (
    .d_i (dreg_q),
    .d_o (data_p)
  );

  for (genvar n = 0; n < 16; n++) begin : g_inv_sbox
    inv_sbox u_inv_sbox (
      .x_i (data_p[4*n +: 4]),
      .y_o (data_s[4*n +: 4])
    );
  end

  assign data_next = data_s ^ key_bwd[79:16];

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      round_q <= '0;
      kreg_q  <= '0;
      dreg_q  <= '0;
      odat_q  <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      round_q <= round_d;
      kreg_q  <= kreg_d;
      dreg_q  <= dreg_d;
      odat_q  <= odat_d;
      done_q  <= done_d;
    end
  end

  always_comb begin
    state_d = state_q;
    round_d = round_q;
    kreg_d  = kreg_q;
    dreg_d  = dreg_q;
    odat_d  = odat_q;
    done_d  = 1'b0;

    if (!chip_enable) begin
      // Frozen: datapath holds, but the output is blanked; a done lost here is gone.
      odat_d = '0;
    end else begin
      unique case (state_q)
        S_IDLE: begin
          if (load) begin
            dreg_d  = idat;
            kreg_d  = key;
            round_d = 5'd1;
            odat_d  = '0;
            state_d = S_KEYEXP;
          end
        end
        S_KEYEXP: begin
          kreg_d = key_fwd;
          if (round_q == LAST_ROUND) begin
            // key_fwd is K32 here: whiten the ciphertext and start unwinding from this round.
            dreg_d  = dreg_q ^ key_fwd[79:16];
            state_d = S_DECRYPT;
          end else begin
            round_d = round_q + 5'd1;
          end
        end
        S_DECRYPT: begin
          dreg_d  = data_next;
          kreg_d  = key_bwd;
          round_d = round_q - 5'd1;
          if (round_q == 5'd1) begin
            odat_d  = data_next;
            done_d  = 1'b1;
            state_d = S_IDLE;
          end
        end
        default: begin
          state_d = S_IDLE;
        end
      endcase
    end
  end

  assign odat = odat_q;
  assign done = done_q;
  // Kept high through the done cycle; done only occurs on the transition back to IDLE.
  assign busy = (state_q != S_IDLE) || done_q;

endmodule

// PRESENT 4-bit S-box.
module sbox (
  input  logic [3:0] x_i,
  output logic [3:0] y_o
);
  always_comb begin
    y_o = 4'h0;
    unique case (x_i)
      4'h0: y_o = 4'hC;
      4'h1: y_o = 4'h5;
      4'h2: y_o = 4'h6;
      4'h3: y_o = 4'hB;
      4'h4: y_o = 4'h9;
      4'h5: y_o = 4'h0;
      4'h6: y_o = 4'hA;
      4'h7: y_o = 4'hD;
      4'h8: y_o = 4'h3;
      4'h9: y_o = 4'hE;
      4'hA: y_o = 4'hF;
      4'hB: y_o = 4'h8;
      4'hC: y_o = 4'h4;
      4'hD: y_o = 4'h7;
      4'hE: y_o = 4'h1;
      4'hF: y_o = 4'h2;
      default: y_o = 4'h0;
    endcase
  end
endmodule

// PRESENT inverse 4-bit S-box.
module inv_sbox (
  input  logic [3:0] x_i,
  output logic [3:0] y_o
);
  always_comb begin
    y_o = 4'h0;
    unique case (x_i)
      4'h0: y_o = 4'h5;
      4'h1: y_o = 4'hE;
      4'h2: y_o = 4'hF;
      4'h3: y_o = 4'h8;
      4'h4: y_o = 4'hC;
      4'h5: y_o = 4'h1;
      4'h6: y_o = 4'h2;
      4'h7: y_o = 4'hD;
      4'h8: y_o = 4'hB;
      4'h9: y_o = 4'h4;
      4'hA: y_o = 4'h6;
      4'hB: y_o = 4'h3;
      4'hC: y_o = 4'h0;
      4'hD: y_o = 4'h7;
      4'hE: y_o = 4'h9;
      4'hF: y_o = 4'hA;
      default: y_o = 4'h0;
    endcase
  end
endmodule

// PRESENT inverse bit permutation: the forward layer sends bit i to (i%4)*16 + i/4,
// so output bit i is read back from that position.
module inv_pbox (
  input  logic [63:0] d_i,
  output logic [63:0] d_o
);
  for (genvar i = 0; i < 64; i++) begin : g_bit
    assign d_o[i] = d_i[(i % 4) * 16 + (i / 4)];
  end
endmodule

// File: tb/tb_present_decrypt.sv
// tb/tb_present_decrypt.sv - self-checking bench for present_decrypt
module tb_present_decrypt;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        chip_enable = 1'b1;
  logic        load = 1'b0;
  logic [63:0] idat = '0;
  logic [79:0] key = '0;
  logic [63:0] odat;
  logic        done;
  logic        busy;

  int n_chk = 0;
  int n_err = 0;

  present_decrypt #(.ROUNDS(31)) dut (
    .clk         (clk),
    .rst         (rst),
    .chip_enable (chip_enable),
    .load        (load),
    .idat        (idat),
    .key         (key),
    .odat        (odat),
    .done        (done),
    .busy        (busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Reference: forward PRESENT-80 encryption written straight from the cipher definition.
  function automatic logic [3:0] ref_s(input logic [3:0] x);
    logic [63:0] tab;
    tab = 64'hC56B90AD3EF84712;
    return tab[4*(15 - int'(x)) +: 4];
  endfunction

  function automatic logic [63:0] ref_encrypt(input logic [63:0] pt, input logic [79:0] k_in);
    logic [63:0] st, sub, perm;
    logic [79:0] k;
    logic [4:0]  rc;
    int          pos;
    st = pt;
    k  = k_in;
    for (int r = 1; r <= 31; r++) begin
      st = st ^ k[79:16];
      for (int n = 0; n < 16; n++) sub[4*n +: 4] = ref_s(st[4*n +: 4]);
      for (int i = 0; i < 64; i++) begin
        pos = (i == 63) ? 63 : (i * 16) % 63;
        perm[pos] = sub[i];
      end
      st = perm;
      k = {k[18:0], k[79:19]};
      k[79:76] = ref_s(k[79:76]);
      rc = 5'(r);
      k[19:15] = k[19:15] ^ rc;
    end
    return st ^ k[79:16];
  endfunction

  task automatic start(input logic [63:0] ct, input logic [79:0] k);
    idat = ct;
    key  = k;
    load = 1'b1;
    tick();
    load = 1'b0;
    idat = {$urandom(), $urandom()};
    key  = {$urandom(), $urandom(), $urandom()};
  endtask

  task automatic wait_done(output int cyc);
    cyc = 0;
    while (!done && cyc < 300) begin
      tick();
      cyc++;
    end
  endtask

  task automatic run_vec(input string tag, input logic [63:0] ct, input logic [79:0] k,
                         input logic [63:0] pt);
    int cyc;
    start(ct, k);
    check({tag, "_busy_start"}, 64'(busy), 64'd1);
    wait_done(cyc);
    check({tag, "_latency"}, 64'(cyc), 64'd62);
    check({tag, "_odat"}, odat, pt);
    check({tag, "_busy_done"}, 64'(busy), 64'd1);
  endtask

  initial begin
    int cyc;
    int hits;
    logic [63:0] pt, ct;
    logic [79:0] k;

    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    check("reset_odat", odat, 64'd0);
    check("reset_done", 64'(done), 64'd0);
    check("reset_busy", 64'(busy), 64'd0);

    // Known-answer vectors.
    run_vec("kat0", 64'h5579C1387B228445, 80'h0, 64'h0);
    tick();
    check("kat0_done_drop", 64'(done), 64'd0);
    check("kat0_busy_drop", 64'(busy), 64'd0);

    run_vec("kat1", 64'hE72C46C0F5945049, {80{1'b1}}, 64'h0);
    tick();

    // Back-to-back: second load presented on the done cycle.
    run_vec("kat2", 64'hA112FFC72F68417B, 80'h0, {64{1'b1}});
    idat = 64'h3333DCD3213210D2;
    key  = {80{1'b1}};
    load = 1'b1;
    tick();
    load = 1'b0;
    check("b2b_odat_cleared", odat, 64'd0);
    check("b2b_busy", 64'(busy), 64'd1);
    wait_done(cyc);
    check("b2b_latency", 64'(cyc), 64'd62);
    check("b2b_odat", odat, {64{1'b1}});
    hits = 0;
    for (int i = 0; i < 5; i++) begin
      tick();
      if (done || odat !== {64{1'b1}}) hits++;
    end
    check("odat_hold", 64'(hits), 64'd0);

    // Load pulses with garbage while busy are ignored.
    start(64'h5579C1387B228445, 80'h0);
    for (int i = 0; i < 50; i++) begin
      load = 1'b1;
      idat = {$urandom(), $urandom()};
      key  = {$urandom(), $urandom(), $urandom()};
      tick();
    end
    load = 1'b0;
    wait_done(cyc);
    check("busy_load_latency", 64'(50 + cyc), 64'd62);
    check("busy_load_odat", odat, 64'd0);
    tick();

    // chip_enable low for 10 cycles in the decrypt phase.
    start(64'hA112FFC72F68417B, 80'h0);
    for (int i = 0; i < 40; i++) tick();
    chip_enable = 1'b0;
    hits = 0;
    for (int i = 0; i < 10; i++) begin
      tick();
      if (done || odat !== 64'd0) hits++;
    end
    chip_enable = 1'b1;
    check("ce_freeze_outputs", 64'(hits), 64'd0);
    wait_done(cyc);
    check("ce_latency", 64'(50 + cyc), 64'd72);
    check("ce_odat", odat, {64{1'b1}});
    tick();

    // Reset mid-operation.
    start(64'h5579C1387B228445, 80'h0);
    for (int i = 0; i < 39; i++) tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("rst_mid_odat", odat, 64'd0);
    check("rst_mid_busy", 64'(busy), 64'd0);
    check("rst_mid_done", 64'(done), 64'd0);
    hits = 0;
    for (int i = 0; i < 80; i++) begin
      tick();
      if (done || busy) hits++;
    end
    check("rst_no_done", 64'(hits), 64'd0);
    run_vec("after_rst", 64'hE72C46C0F5945049, {80{1'b1}}, 64'h0);
    tick();

    // Random round trips through the reference encryptor.
    for (int v = 0; v < 300; v++) begin
      pt = {$urandom(), $urandom()};
      k  = {$urandom(), $urandom(), $urandom()};
      ct = ref_encrypt(pt, k);
      start(ct, k);
      wait_done(cyc);
      check("rand_latency", 64'(cyc), 64'd62);
      check("rand_odat", odat, pt);
      if ($urandom_range(0, 1) == 0) tick();
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
